spm_stream_ctrl: RTL and testbench

- Stream-to-RAM sequencer that sits in front of the 16x8 single-port RAM and drives its data/addr/we pins.
- Buffers one frame of up to 16 bytes from a valid/ready input stream into the RAM.
- Replays the frame on a valid/ready output stream.
- Handles the RAM's one-cycle registered-address read latency and output backpressure.

---
 rtl/spm_stream_ctrl_if.sv | 41 ++++
 rtl/spm_stream_ctrl.sv | 133 +++++++++++++
 tb/tb_spm_stream_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spm_stream_ctrl_if.sv
// ============================================================================
// Module      : spm_stream_ctrl_if
// Description : Input stream, output stream and RAM pin bundle for spm_stream_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spm_stream_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;
  logic              busy;

  // Controller side
  modport master (
    input  in_data, in_valid, in_last, out_ready, mem_q,
    output in_ready, out_data, out_valid, out_last,
           mem_data, mem_addr, mem_we, busy
  );

  // Environment side: stream source/sink and RAM
  modport slave (
    output in_data, in_valid, in_last, out_ready, mem_q,
    input  in_ready, out_data, out_valid, out_last,
           mem_data, mem_addr, mem_we, busy
  );
endinterface

`default_nettype wire

// File: rtl/spm_stream_ctrl.sv
// ============================================================================
// Module      : spm_stream_ctrl
// Description : Buffers one frame (<= 2**ADDR_W words) from a valid/ready stream
//               into a single-port RAM and replays it on an output stream.
//               Define SPM_STREAM_REVERSE_EN to replay the frame in LIFO order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spm_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  spm_stream_ctrl_if.master  bus
);

  localparam logic [ADDR_W-1:0] c_ptr_one     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_len_one     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_len_full_m1 = (ADDR_W+1)'((1 << ADDR_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_PRIME = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_len;
  logic              r_out_valid;
  logic              r_busy;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_frame_end;
  logic              w_fire;
  logic              w_at_end;
  logic [ADDR_W-1:0] w_rd_next;
  logic [ADDR_W-1:0] w_rd_start;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_rd_data;

  // Gated by rst_n so nothing is accepted or written while reset is held.
  assign w_in_ready  = rst_n & ((r_state == S_IDLE) | (r_state == S_FILL));
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_frame_end = bus.in_last | (r_len == c_len_full_m1);
  assign w_fire      = r_out_valid & bus.out_ready;

`ifdef SPM_STREAM_REVERSE_EN
  assign w_at_end   = (r_rd_ptr == '0);
  assign w_rd_next  = r_rd_ptr - c_ptr_one;
  assign w_rd_start = r_len[ADDR_W-1:0] - c_ptr_one;
`else
  logic [ADDR_W:0] w_len_m1;
  assign w_len_m1   = r_len - c_len_one;
  assign w_at_end   = ({1'b0, r_rd_ptr} == w_len_m1);
  assign w_rd_next  = r_rd_ptr + c_ptr_one;
  assign w_rd_start = '0;
`endif

  // The RAM registers its address, so the next read address must be presented
  // in the same cycle the current word is consumed.
  always_comb begin
    w_mem_addr = r_wr_ptr;
    case (r_state)
      S_IDLE, S_FILL: w_mem_addr = r_wr_ptr;
      S_PRIME:        w_mem_addr = w_rd_start;
      S_DRAIN:        w_mem_addr = w_fire ? w_rd_next : r_rd_ptr;
      default:        w_mem_addr = r_wr_ptr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
            r_len    <= r_len + c_len_one;
            r_busy   <= 1'b1;
            r_state  <= w_frame_end ? S_PRIME : S_FILL;
          end
        end
        S_PRIME: begin
          r_rd_ptr    <= w_rd_start;
          r_out_valid <= 1'b1;
          r_state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_fire) begin
            r_rd_ptr <= w_rd_next;
            if (w_at_end) begin
              r_out_valid <= 1'b0;
              r_wr_ptr    <= '0;
              r_len       <= '0;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign w_rd_data     = bus.mem_q;
  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_accept;
  assign bus.mem_data  = bus.in_data;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.out_data  = w_rd_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_valid & w_at_end;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spm_stream_ctrl.sv
// ============================================================================
// Module      : tb_spm_stream_ctrl
// Description : Directed bench for spm_stream_ctrl with a 16x8 registered-address
//               RAM model. Honours SPM_STREAM_REVERSE_EN for replay order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spm_stream_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef SPM_STREAM_REVERSE_EN
  localparam bit c_rev = 1'b1;
`else
  localparam bit c_rev = 1'b0;
`endif

  spm_stream_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  spm_stream_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // 16x8 single-port RAM, q = ram[address registered last edge]
  logic [7:0] ram [16];
  logic [3:0] ram_addr_q = 4'd0;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
    ram_addr_q <= bus.mem_addr;
  end
  assign bus.mem_q = ram[ram_addr_q];

  logic [7:0] fr [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push fr[first..n-1] at addresses first..n-1, then check the PRIME cycle.
  task automatic send_frame(input int n, input int first, input bit use_last,
                            input bit hold, input logic [7:0] hold_byte);
    for (int i = first; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
      bus.in_last  = use_last && (i == n - 1);
      @(negedge clk);
      chk("fill_in_ready", bus.in_ready, 1);
      chk("fill_mem_we", bus.mem_we, 1);
      chk("fill_mem_addr", bus.mem_addr, i);
      step();
    end
    bus.in_valid = hold;
    bus.in_data  = hold_byte;
    bus.in_last  = 1'b0;
    @(negedge clk);
    chk("prime_busy", bus.busy, 1);
    chk("prime_out_valid", bus.out_valid, 0);
    chk("prime_in_ready", bus.in_ready, 0);
    chk("prime_mem_we", bus.mem_we, 0);
    chk("prime_mem_addr", bus.mem_addr, c_rev ? n - 1 : 0);
    step();
  endtask

  // Drain n bytes, stalling `stall` cycles before each; ends at a negedge.
  task automatic drain_frame(input int n, input int stall);
    int idx;
    logic [3:0] nxt;
    for (int i = 0; i < n; i++) begin
      idx = c_rev ? n - 1 - i : i;
      nxt = c_rev ? 4'(idx - 1) : 4'(idx + 1);
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_out_valid", bus.out_valid, 1);
          chk("stall_out_data", bus.out_data, fr[idx]);
          chk("stall_mem_addr", bus.mem_addr, idx);
          step();
        end
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("drain_out_valid", bus.out_valid, 1);
      chk("drain_out_data", bus.out_data, fr[idx]);
      chk("drain_out_last", bus.out_last, i == n - 1);
      chk("drain_mem_addr", bus.mem_addr, nxt);
      chk("drain_mem_we", bus.mem_we, 0);
      step();
    end
    @(negedge clk);
    chk("done_busy", bus.busy, 0);
    chk("done_out_valid", bus.out_valid, 0);
    chk("done_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_out_last", bus.out_last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_busy", bus.busy, 0);

    // in_last without in_valid is ignored
    bus.in_last = 1'b1;
    step();
    bus.in_last = 1'b0;
    chk("lone_last_busy", bus.busy, 0);

    // Basic 4-byte frame
    fr = '{8'h8D, 8'h8E, 8'h8F, 8'h90};
    send_frame(4, 0, 1'b1, 1'b0, 8'h00);
    drain_frame(4, 0);
    step();

    // Capacity: 16 bytes without in_last, 0x10 waits for the next frame
    fr.delete();
    for (int i = 0; i < 16; i++) fr.push_back(8'(i));
    send_frame(16, 0, 1'b0, 1'b1, 8'h10);
    drain_frame(16, 0);
    chk("next_mem_we", bus.mem_we, 1);
    chk("next_mem_addr", bus.mem_addr, 0);
    step();
    fr = '{8'h10, 8'h11, 8'h12, 8'h13};
    send_frame(4, 1, 1'b1, 1'b0, 8'h00);
    drain_frame(4, 0);
    step();

    // Backpressure
    fr = '{8'hA1, 8'hA2, 8'hA3};
    send_frame(3, 0, 1'b1, 1'b0, 8'h00);
    drain_frame(3, 5);
    step();

    // Single-byte frame
    fr = '{8'h5A};
    send_frame(1, 0, 1'b1, 1'b0, 8'h00);
    drain_frame(1, 0);
    step();

    // Asynchronous reset mid-drain
    fr = '{8'h31, 8'h32, 8'h33, 8'h34};
    send_frame(4, 0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("pre_rst_out_data", bus.out_data, c_rev ? fr[3] : fr[0]);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_out_last", bus.out_last, 0);
    chk("arst_mem_we", bus.mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rel_in_ready", bus.in_ready, 1);
    step();
    fr = '{8'h11, 8'h22};
    send_frame(2, 0, 1'b1, 1'b0, 8'h00);
    drain_frame(2, 0);
    step();

    // Small frame for replay order
    fr = '{8'h01, 8'h02, 8'h03};
    send_frame(3, 0, 1'b1, 1'b0, 8'h00);
    drain_frame(3, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
